// File: rtl/riscv_nn_wb_pkg.sv
// Shared types for the write-back arbiter slice.
// Holds RF field widths, the FP bank select bit and the wb_req_t bundle.
package riscv_nn_wb_pkg;

    localparam int WB_ADDR_W   = 6;
    localparam int WB_DATA_W   = 32;
    localparam int FP_BANK_BIT = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/riscv_nn_wb_fifo.sv
// Multicycle result FIFO for the write-back stage.
// Ports: clk, rst_n, push_i/din_i (write side), pop_i/dout_o (head, popped
// when pop_i and not empty), full_o, empty_o. DEPTH is a power of 2, >=2.
module riscv_nn_wb_fifo
    import riscv_nn_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t din_i,
    input  logic    pop_i,
    output wb_req_t dout_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    wb_req_t     mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra MSB on each pointer tells full apart from empty.
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    // A pop frees a slot in the same cycle, so a full FIFO may also push.
    assign do_push = push_i && (!full_o || do_pop);

    assign dout_o  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din_i;
    end

endmodule

// File: rtl/riscv_nn_wb_arbiter.sv
// Write-back arbiter: merges EX, LSU and multicycle results onto RF ports
// A (EX / multicycle) and B (LSU), and keeps a pending-write scoreboard.
// Ports: ex_*, lsu_* (always accepted), mc_* (valid/ready), issue_*,
// pending_o, we/waddr/wdata for ports A and B (all registered).
// Optional: RISCV_NN_WB_MC_BYPASS_EN lets an mc result skip an empty FIFO.
module riscv_nn_wb_arbiter
    import riscv_nn_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int MC_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    input  logic [ADDR_WIDTH-1:0]    ex_waddr_i,
    input  logic [DATA_WIDTH-1:0]    ex_wdata_i,
    input  logic                     lsu_valid_i,
    input  logic [ADDR_WIDTH-1:0]    lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]    lsu_wdata_i,
    input  logic                     mc_valid_i,
    output logic                     mc_ready_o,
    input  logic [ADDR_WIDTH-1:0]    mc_waddr_i,
    input  logic [DATA_WIDTH-1:0]    mc_wdata_i,
    input  logic                     issue_i,
    input  logic [ADDR_WIDTH-1:0]    issue_waddr_i,
    output logic [2**ADDR_WIDTH-1:0] pending_o,
    output logic                     we_a_o,
    output logic [ADDR_WIDTH-1:0]    waddr_a_o,
    output logic [DATA_WIDTH-1:0]    wdata_a_o,
    output logic                     we_b_o,
    output logic [ADDR_WIDTH-1:0]    waddr_b_o,
    output logic [DATA_WIDTH-1:0]    wdata_b_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    wb_req_t                mc_req;
    wb_req_t                head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   hold;
    logic                   byp;

    logic                   a_we_d;
    logic [ADDR_WIDTH-1:0]  a_addr_d;
    logic [DATA_WIDTH-1:0]  a_data_d;
    logic                   clr_vld;
    logic [ADDR_WIDTH-1:0]  clr_addr;

    logic [NREG-1:0]        pend_q;
    logic [NREG-1:0]        pend_d;

    assign mc_ready_o = !fifo_full;
    assign mc_req     = '{addr: mc_waddr_i, data: mc_wdata_i};

    // Holding the head while LSU writes the same register keeps the
    // older load and the newer multicycle write in a fixed order.
    assign hold = lsu_valid_i && (lsu_waddr_i == head.addr);
    assign pop  = !ex_valid_i && !fifo_empty && !hold;

`ifdef RISCV_NN_WB_MC_BYPASS_EN
    assign byp = mc_valid_i && fifo_empty && !ex_valid_i &&
                 !(lsu_valid_i && (lsu_waddr_i == mc_waddr_i));
`else
    assign byp = 1'b0;
`endif

    assign push = mc_valid_i && mc_ready_o && !byp;

    riscv_nn_wb_fifo #(
        .DEPTH (MC_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (mc_req),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Port A source select; the three cases are mutually exclusive.
    always_comb begin
        a_we_d   = 1'b0;
        a_addr_d = waddr_a_o;
        a_data_d = wdata_a_o;
        clr_vld  = 1'b0;
        clr_addr = head.addr;
        unique case (1'b1)
            ex_valid_i: begin
                a_we_d   = |ex_waddr_i;
                a_addr_d = ex_waddr_i;
                a_data_d = ex_wdata_i;
            end
            pop: begin
                a_we_d   = |head.addr;
                a_addr_d = head.addr;
                a_data_d = head.data;
                clr_vld  = 1'b1;
            end
            byp: begin
                a_we_d   = |mc_waddr_i;
                a_addr_d = mc_waddr_i;
                a_data_d = mc_wdata_i;
                clr_vld  = 1'b1;
                clr_addr = mc_waddr_i;
            end
            default: ;
        endcase
    end

    // Set after clear so a same-cycle set wins; x0 never pends.
    always_comb begin
        pend_d = pend_q;
        if (clr_vld) pend_d[clr_addr] = 1'b0;
        if (issue_i) pend_d[issue_waddr_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    assign pending_o = pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_o    <= 1'b0;
            waddr_a_o <= '0;
            wdata_a_o <= '0;
            we_b_o    <= 1'b0;
            waddr_b_o <= '0;
            wdata_b_o <= '0;
            pend_q    <= '0;
        end else begin
            we_a_o    <= a_we_d;
            waddr_a_o <= a_addr_d;
            wdata_a_o <= a_data_d;
            we_b_o    <= lsu_valid_i && (|lsu_waddr_i);
            if (lsu_valid_i) begin
                waddr_b_o <= lsu_waddr_i;
                wdata_b_o <= lsu_wdata_i;
            end
            pend_q    <= pend_d;
        end
    end

endmodule
